// File: rtl/led_display_row_fetch.sv
// ---------------------------------------------------------------------------
// led_display_row_fetch
//
// Walks the pixel RAM of a HUB75-style LED panel and feeds the PHY one pixel
// pair per column. The upper and lower panel halves are scanned together:
// each pair holds pixel (row, col) and pixel (row + NUM_ROW_PIXELS/2, col).
// Each pair takes two RAM reads, one capture cycle and one output cycle, so
// the fastest rate is one pair every four cycles.
//
// Ports
//   clk_in          system clock
//   reset_in        synchronous active-high reset
//   frame_start_in  one-cycle request to fetch a full frame (ignored if busy)
//   ram_rd_en_out   pixel RAM read strobe
//   ram_addr_out    pixel RAM address, row*NUM_COL_PIXELS + col
//   ram_data_in     {R,G,B} read data, valid one cycle after the strobe
//   pix_valid_out   pixel pair available to the PHY
//   pix_ready_in    PHY accepts the pair (transfer on valid & ready)
//   pix_top_out     {R,G,B} of the upper-half pixel
//   pix_bot_out     {R,G,B} of the lower-half pixel
//   row_sel_out     current row-pair index
//   line_last_out   high with the pair at the last column
//   busy_out        high from frame accept until the final transfer
//   frame_done_out  one-cycle pulse after the last pair is accepted
// ---------------------------------------------------------------------------
module led_display_row_fetch #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    localparam int ADDR_W = $clog2(NUM_ROW_PIXELS * NUM_COL_PIXELS),
    localparam int ROW_W  = $clog2(NUM_ROW_PIXELS / 2),
    localparam int COL_W  = $clog2(NUM_COL_PIXELS)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              frame_start_in,
    output logic              ram_rd_en_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    input  logic [2:0]        ram_data_in,
    output logic              pix_valid_out,
    input  logic              pix_ready_in,
    output logic [2:0]        pix_top_out,
    output logic [2:0]        pix_bot_out,
    output logic [ROW_W-1:0]  row_sel_out,
    output logic              line_last_out,
    output logic              busy_out,
    output logic              frame_done_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOP = 3'd1,
        RD_BOT = 3'd2,
        CAPT   = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COL_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROW_PIXELS / 2 - 1);

    state_t              state_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          top_q;
    logic [2:0]          bot_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;

    logic                last_col;
    logic                last_row;
    logic [ROW_W-1:0]    row_d;
    logic [COL_W-1:0]    col_d;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    // Position of the next pair; only used when the frame is not finished,
    // so the row never steps past ROW_LAST and the column wraps to 0.
    always_comb begin
        col_d = last_col ? '0 : col_q + COL_W'(1);
        row_d = last_col ? row_q + ROW_W'(1) : row_q;
    end

    // Addresses are formed by concatenation: the lower-half row is the
    // upper-half row with the extra MSB set, i.e. row + NUM_ROW_PIXELS/2.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start_in) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RD_TOP;
                    end
                end
                RD_TOP: begin
                    addr_q  <= {1'b1, row_q, col_q};
                    state_q <= RD_BOT;
                end
                RD_BOT: begin
                    // Data for the upper-half read arrives this cycle.
                    top_q   <= ram_data_in;
                    rd_en_q <= 1'b0;
                    state_q <= CAPT;
                end
                CAPT: begin
                    bot_q   <= ram_data_in;
                    valid_q <= 1'b1;
                    last_q  <= last_col;
                    state_q <= OUT;
                end
                OUT: begin
                    if (pix_ready_in) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_col && last_row) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            row_q   <= row_d;
                            col_q   <= col_d;
                            rd_en_q <= 1'b1;
                            addr_q  <= {1'b0, row_d, col_d};
                            state_q <= RD_TOP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_rd_en_out  = rd_en_q;
    assign ram_addr_out   = addr_q;
    assign pix_valid_out  = valid_q;
    assign pix_top_out    = top_q;
    assign pix_bot_out    = bot_q;
    assign row_sel_out    = row_q;
    assign line_last_out  = last_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_led_display_row_fetch.sv
module tb_led_display_row_fetch;

    localparam int NR     = 32;
    localparam int NC     = 64;
    localparam int NPAIR  = (NR / 2) * NC;
    localparam int BUDGET = 30000;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        frame_start_in = 1'b0;
    logic        ram_rd_en_out;
    logic [10:0] ram_addr_out;
    logic [2:0]  ram_data_in = 3'd0;
    logic        pix_valid_out;
    logic        pix_ready_in = 1'b0;
    logic [2:0]  pix_top_out;
    logic [2:0]  pix_bot_out;
    logic [3:0]  row_sel_out;
    logic        line_last_out;
    logic        busy_out;
    logic        frame_done_out;

    int n_run  = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    logic [2:0] mem [NR*NC];

    led_display_row_fetch #(
        .NUM_ROW_PIXELS(NR),
        .NUM_COL_PIXELS(NC)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .frame_start_in(frame_start_in),
        .ram_rd_en_out (ram_rd_en_out),
        .ram_addr_out  (ram_addr_out),
        .ram_data_in   (ram_data_in),
        .pix_valid_out (pix_valid_out),
        .pix_ready_in  (pix_ready_in),
        .pix_top_out   (pix_top_out),
        .pix_bot_out   (pix_bot_out),
        .row_sel_out   (row_sel_out),
        .line_last_out (line_last_out),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read RAM: data one cycle after the strobe, junk otherwise.
    always @(posedge clk_in) begin
        if (ram_rd_en_out) ram_data_in <= mem[ram_addr_out];
        else               ram_data_in <= 3'($urandom);
        if (ram_rd_en_out)  rd_cnt   <= rd_cnt + 1;
        if (frame_done_out) done_cnt <= done_cnt + 1;
    end

    function automatic logic [25:0] all_outs();
        return {ram_rd_en_out, ram_addr_out, pix_valid_out, pix_top_out, pix_bot_out,
                row_sel_out, line_last_out, busy_out, frame_done_out};
    endfunction

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < NR*NC; i++) begin
            logic [10:0] a;
            a = 11'(i);
            mem[i] = pattern ? a[2:0] : 3'($urandom);
        end
    endtask

    task automatic pulse_start();
        rd_cnt = 0;
        done_cnt = 0;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Accepts every pair of one frame with a random ready pattern and compares
    // each accepted pair with the panel image in mem, scanned row-major.
    task automatic drain_frame(input int pct, input bit poke);
        int idx = 0;
        int cyc = 0;
        while (idx < NPAIR && cyc < BUDGET) begin
            pix_ready_in   = ($urandom_range(99) < pct);
            frame_start_in = poke && busy_out && ($urandom_range(15) == 0);
            if (pix_valid_out && ram_rd_en_out) begin
                n_run++; n_fail++;
                $display("FAIL overlap: valid and read strobe both high at pair %0d", idx);
            end
            if (pix_valid_out && pix_ready_in) begin
                int r, c;
                logic [10:0] exp;
                r = idx / NC;
                c = idx % NC;
                exp = {mem[r*NC + c], mem[(r + NR/2)*NC + c], 4'(r), (c == NC-1)};
                n_run++;
                if ({pix_top_out, pix_bot_out, row_sel_out, line_last_out} !== exp) begin
                    n_fail++;
                    $display("FAIL pair r%0d c%0d: got top=%0d bot=%0d row=%0d last=%0d, want top=%0d bot=%0d row=%0d last=%0d",
                             r, c, pix_top_out, pix_bot_out, row_sel_out, line_last_out,
                             exp[10:8], exp[7:5], exp[4:1], exp[0]);
                end
                idx++;
            end
            @(negedge clk_in);
            cyc++;
        end
        frame_start_in = 1'b0;
        pix_ready_in   = 1'b0;
        n_run++;
        if (idx < NPAIR) begin
            n_fail++;
            $display("FAIL frame_timeout: got %0d pairs, want %0d", idx, NPAIR);
        end else begin
            if (frame_done_out !== 1'b1 || busy_out !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_end: got done=%b busy=%b, want done=1 busy=0",
                         frame_done_out, busy_out);
            end
            @(negedge clk_in);
            n_run++;
            if (frame_done_out !== 1'b0 || done_cnt != 1 || rd_cnt != 2*NPAIR) begin
                n_fail++;
                $display("FAIL frame_totals: got done=%b pulses=%0d reads=%0d, want done=0 pulses=1 reads=%0d",
                         frame_done_out, done_cnt, rd_cnt, 2*NPAIR);
            end
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        n_run++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        reset_in = 1'b0;
        @(negedge clk_in);
        n_run++;
        if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: got busy=%b rd=%b, want 0 0", busy_out, ram_rd_en_out);
        end
    endtask

    task automatic test_first_pixel_and_stall();
        logic [10:0] held;
        fill_mem(1'b1);
        pulse_start();
        n_run++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 11'd0 || busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_read_top: got rd=%b addr=%0d busy=%b, want 1 0 1",
                     ram_rd_en_out, ram_addr_out, busy_out);
        end
        @(negedge clk_in);
        n_run++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 11'd1024) begin
            n_fail++;
            $display("FAIL first_read_bot: got rd=%b addr=%0d, want 1 1024", ram_rd_en_out, ram_addr_out);
        end
        @(negedge clk_in);
        n_run++;
        if (ram_rd_en_out !== 1'b0 || pix_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL capt_cycle: got rd=%b valid=%b, want 0 0", ram_rd_en_out, pix_valid_out);
        end
        @(negedge clk_in);
        n_run++;
        if (pix_valid_out !== 1'b1 || row_sel_out !== 4'd0 || pix_top_out !== 3'd0 || pix_bot_out !== 3'd0) begin
            n_fail++;
            $display("FAIL first_valid: got valid=%b row=%0d top=%0d bot=%0d, want 1 0 0 0",
                     pix_valid_out, row_sel_out, pix_top_out, pix_bot_out);
        end
        held = {pix_top_out, pix_bot_out, row_sel_out, line_last_out};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            n_run++;
            if (pix_valid_out !== 1'b1 || ram_rd_en_out !== 1'b0 ||
                {pix_top_out, pix_bot_out, row_sel_out, line_last_out} !== held) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: got valid=%b rd=%b data=%h, want 1 0 %h",
                         i, pix_valid_out, ram_rd_en_out,
                         {pix_top_out, pix_bot_out, row_sel_out, line_last_out}, held);
            end
        end
        drain_frame(100, 1'b0);
    endtask

    task automatic test_random_frame();
        fill_mem(1'b0);
        pulse_start();
        drain_frame(60, 1'b1);
    endtask

    task automatic test_back_to_back();
        fill_mem(1'b0);
        pulse_start();
        drain_frame(100, 1'b1);
        pulse_start();
        drain_frame(35, 1'b0);
    endtask

    task automatic test_reset_midframe();
        int cyc = 0;
        fill_mem(1'b1);
        pulse_start();
        pix_ready_in = 1'b1;
        while (!(pix_valid_out && row_sel_out == 4'd7) && cyc < BUDGET) begin
            @(negedge clk_in);
            cyc++;
        end
        pix_ready_in = 1'b0;
        reset_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        n_run++;
        if (all_outs() !== '0 || cyc >= BUDGET) begin
            n_fail++;
            $display("FAIL reset_midframe: got %h (waited %0d), want 0", all_outs(), cyc);
        end
        @(negedge clk_in);
        pulse_start();
        n_run++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 11'd0) begin
            n_fail++;
            $display("FAIL restart_addr: got rd=%b addr=%0d, want 1 0", ram_rd_en_out, ram_addr_out);
        end
        drain_frame(80, 1'b0);
    endtask

    task automatic test_start_with_reset();
        reset_in = 1'b1;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        reset_in = 1'b0;
        frame_start_in = 1'b0;
        n_run++;
        if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_reset: got busy=%b rd=%b, want 0 0", busy_out, ram_rd_en_out);
        end
        repeat (3) @(negedge clk_in);
        n_run++;
        if (busy_out !== 1'b0 || ram_rd_en_out !== 1'b0 || pix_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stays_idle: got busy=%b rd=%b valid=%b, want 0 0 0",
                     busy_out, ram_rd_en_out, pix_valid_out);
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_first_pixel_and_stall();
        test_random_frame();
        test_back_to_back();
        test_reset_midframe();
        test_start_with_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/led_display_row_fetch.md
LED_DISPLAY_ROW_FETCH -- requirements
Module: led_display_row_fetch

Interface
REQ-001 Parameter NUM_ROW_PIXELS, default 32: panel rows; SHALL be even, power of two.
REQ-002 Parameter NUM_COL_PIXELS, default 64: panel columns; SHALL be a power of two.
REQ-003 Derived ADDR_W = clog2(NUM_ROW_PIXELS*NUM_COL_PIXELS) (11); ROW_W = clog2(NUM_ROW_PIXELS/2) (4); COL_W = clog2(NUM_COL_PIXELS) (6).
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 frame_start_in  input  1  single-cycle request to fetch one full frame.
REQ-007 ram_rd_en_out  output  1  pixel RAM read strobe.
REQ-008 ram_addr_out  output  ADDR_W  pixel RAM address = row*NUM_COL_PIXELS + col.
REQ-009 ram_data_in  input  3  {R,G,B} read data, valid exactly 1 cycle after ram_rd_en_out.
REQ-010 pix_valid_out  output  1  pixel pair available to the PHY.
REQ-011 pix_ready_in  input  1  PHY accepts the pair; transfer when valid and ready both high.
REQ-012 pix_top_out  output  3  {R,G,B} of upper-half row pixel.
REQ-013 pix_bot_out  output  3  {R,G,B} of lower-half row pixel (row + NUM_ROW_PIXELS/2).
REQ-014 row_sel_out  output  ROW_W  current row-pair index 0..NUM_ROW_PIXELS/2-1.
REQ-015 line_last_out  output  1  high with the pair at column NUM_COL_PIXELS-1.
REQ-016 busy_out  output  1  high from frame accept until the final transfer.
REQ-017 frame_done_out  output  1  one-cycle pulse after the last pair of a frame is accepted.

Function
REQ-018 FSM states SHALL be IDLE, RD_TOP, RD_BOT, CAPT, OUT.
REQ-019 IDLE: frame_start_in high -> row=0, col=0, RD_TOP next cycle; otherwise stay.
REQ-020 RD_TOP: ram_rd_en_out=1, ram_addr_out=row*NUM_COL_PIXELS+col; -> RD_BOT.
REQ-021 RD_BOT: ram_rd_en_out=1, ram_addr_out=(row+NUM_ROW_PIXELS/2)*NUM_COL_PIXELS+col; capture ram_data_in into top register; -> CAPT.
REQ-022 CAPT: ram_rd_en_out=0; capture ram_data_in into bottom register; -> OUT.
REQ-023 OUT: pix_valid_out=1; without a transfer, stay with pix_top_out, pix_bot_out, row_sel_out, line_last_out held stable.
REQ-024 Transfer in OUT, col<NUM_COL_PIXELS-1: col+1, -> RD_TOP.
REQ-025 Transfer in OUT, col=NUM_COL_PIXELS-1, row<NUM_ROW_PIXELS/2-1: col=0, row+1, -> RD_TOP.
REQ-026 Transfer in OUT, last col and last row: -> IDLE; frame_done_out=1 in the following cycle only.
REQ-027 First pix_valid_out SHALL assert 4 cycles after the edge sampling frame_start_in; steady-state throughput is one pair per 4 cycles with pix_ready_in held high.
REQ-028 frame_start_in outside IDLE SHALL be ignored; it is not queued.
REQ-029 pix_valid_out SHALL be 0 in every state except OUT; ram_rd_en_out SHALL be 0 outside RD_TOP/RD_BOT.
REQ-030 busy_out SHALL be 1 in every state except IDLE.
REQ-031 Counters SHALL not wrap past their limits; row and column arithmetic stays within ROW_W/COL_W.

Reset
REQ-032 reset_in high at a clock edge SHALL force IDLE, row=0, col=0; all outputs 0 from the next cycle, including mid-frame.
REQ-033 reset_in SHALL take precedence over frame_start_in and pix_ready_in in the same cycle.

Verification
REQ-034 Reset, then frame_start_in pulse -> cycle+1 ram_addr_out=0; cycle+2 ram_addr_out=1024; cycle+4 pix_valid_out=1, row_sel_out=0.
REQ-035 RAM model data = addr[2:0], pix_ready_in=1 -> 1024 pairs in row-major order; pair (row 3, col 5) gives top=5, bot=5; line_last_out on col 63 only; a single frame_done_out pulse.
REQ-036 pix_ready_in held low 10 cycles during OUT -> outputs stable, no new RAM reads, then one transfer on release.
REQ-037 frame_start_in pulsed while busy_out=1 -> no effect; exactly 1024 transfers, one frame_done_out.
REQ-038 reset_in asserted during row 7 -> next cycle all outputs 0, busy_out=0; a new frame_start_in restarts at address 0.
REQ-039 frame_start_in and reset_in high together -> stays IDLE, busy_out=0.
